// File: rtl/cpu5_ifu_pkg.sv
// cpu5_ifu_pkg: shared definitions for the CPU5 instruction fetch unit.
// Holds the default address width, the default reset vector, the fetch
// FSM state encoding and the fixed instruction width.
package cpu5_ifu_pkg;

  // Default machine word / address width of the CPU5 core
  localparam int CPU5_XLEN = 32;

  // Default first fetch address after reset
  localparam logic [31:0] CPU5_IFU_RESET_VEC = 32'h0000_0000;

  // Instructions are always one 32-bit word regardless of XLEN
  localparam int CPU5_INSTR_W = 32;

  // Sequential fetch step in bytes
  localparam int CPU5_PC_STEP = 4;

  // Fetch FSM states:
  //   IDLE - buffer full, no request issued
  //   REQ  - request presented, waiting for grant
  //   WAIT - request granted, waiting for read data
  //   DROP - a redirect orphaned the granted request; swallow its data
  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_DROP = 2'd3
  } ifu_state_t;

endpackage

// File: rtl/cpu5_adder.sv
// cpu5_adder: shared plain modular adder used across the CPU5 core.
// The sum wraps at 2^WIDTH; no carry out is produced.
module cpu5_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/cpu5_ifu_fifo.sv
// cpu5_ifu_fifo: small instruction buffer for the fetch unit.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// flush has priority over push and pop and empties the buffer in one cycle.
// Storage is reset to zero so the head reads zero straight out of reset.
module cpu5_ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pops never underflow; pushes into a full buffer only land if a pop frees a slot
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  assign head = mem[rd_ptr];

  // Storage write port; flush suppresses the write so a flushed entry never appears
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping, flush first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/cpu5_ifu.sv
// cpu5_ifu: CPU5 instruction fetch unit.
// Issues one word-aligned fetch at a time, buffers returned instructions
// in cpu5_ifu_fifo and presents the head to decode. A redirect from
// execute flushes the buffer, restarts fetch at the aligned target and
// discards any response still owed for the abandoned request.
// Optional feature: define CPU5_IFU_PERF_EN to build the fetch/flush
// performance counters; otherwise both counter outputs are tied to zero.
module cpu5_ifu
  import cpu5_ifu_pkg::*;
#(
  parameter int              XLEN      = CPU5_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(CPU5_IFU_RESET_VEC),
  parameter int              DEPTH     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [XLEN-1:0]         imem_addr,
  input  logic                    imem_gnt,
  input  logic                    imem_rvalid,
  input  logic [CPU5_INSTR_W-1:0] imem_rdata,
  input  logic                    redirect,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic                    ifu_valid,
  output logic [CPU5_INSTR_W-1:0] ifu_instr,
  output logic [XLEN-1:0]         ifu_pc,
  input  logic                    ifu_ready,
  output logic [31:0]             perf_fetch_cnt,
  output logic [31:0]             perf_flush_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + CPU5_INSTR_W;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(CPU5_PC_STEP);

  ifu_state_t       state;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  redirect_target;
  logic [CW-1:0]    buf_count;
  logic [CW-1:0]    count_post;
  logic [EW-1:0]    buf_head;
  logic             push;
  logic             pop;
  logic             has_room;
  logic             room_after;
  logic             unused_redirect_lsbs;

  // Targets are forced to a word boundary; the dropped low bits go to a named sink
  assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Only a response to the live request in WAIT is kept, and a redirect kills it
  assign push = (state == IFU_WAIT) && imem_rvalid && !redirect;
  assign pop  = ifu_valid && ifu_ready;

  // Occupancy after this cycle's push/pop decides whether to keep fetching
  assign count_post = buf_count + CW'(push) - CW'(pop);
  assign has_room   = (buf_count < CW'(DEPTH));
  assign room_after = (count_post < CW'(DEPTH));

  assign imem_addr = fetch_pc;
  assign ifu_valid = (buf_count != '0);
  assign ifu_pc    = buf_head[EW-1:CPU5_INSTR_W];
  assign ifu_instr = buf_head[CPU5_INSTR_W-1:0];

  cpu5_adder #(
    .WIDTH(XLEN)
  ) u_pc_adder (
    .a  (fetch_pc),
    .b  (PC_STEP),
    .sum(pc_plus4)
  );

  cpu5_ifu_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (redirect),
    .push_data({fetch_pc, imem_rdata}),
    .count    (buf_count),
    .head     (buf_head)
  );

  // Fetch FSM with fetch PC and registered request; redirect overrides normal flow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IFU_IDLE;
      fetch_pc <= RESET_VEC;
      imem_req <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_target;
      case (state)
        IFU_IDLE: begin
          state    <= IFU_REQ;
          imem_req <= 1'b1;
        end
        IFU_REQ: begin
          if (imem_gnt) begin
            state    <= IFU_DROP;
            imem_req <= 1'b0;
          end else begin
            state    <= IFU_REQ;
            imem_req <= 1'b1;
          end
        end
        IFU_WAIT: begin
          if (imem_rvalid) begin
            state    <= IFU_REQ;
            imem_req <= 1'b1;
          end else begin
            state    <= IFU_DROP;
            imem_req <= 1'b0;
          end
        end
        IFU_DROP: begin
          if (imem_rvalid) begin
            state    <= IFU_REQ;
            imem_req <= 1'b1;
          end else begin
            state    <= IFU_DROP;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IFU_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end else begin
      case (state)
        IFU_IDLE: begin
          if (has_room) begin
            state    <= IFU_REQ;
            imem_req <= 1'b1;
          end
        end
        IFU_REQ: begin
          if (imem_gnt) begin
            state    <= IFU_WAIT;
            imem_req <= 1'b0;
          end
        end
        IFU_WAIT: begin
          if (imem_rvalid) begin
            fetch_pc <= pc_plus4;
            if (room_after) begin
              state    <= IFU_REQ;
              imem_req <= 1'b1;
            end else begin
              state    <= IFU_IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        IFU_DROP: begin
          if (imem_rvalid) begin
            state    <= IFU_REQ;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= IFU_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef CPU5_IFU_PERF_EN
  logic flush_discards;

  // A redirect only counts as a flush if it throws away a buffered or granted fetch
  assign flush_discards = redirect &&
                          ((buf_count != '0) ||
                           (state == IFU_WAIT) ||
                           ((state == IFU_REQ) && imem_gnt));

  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(push);
      perf_flush_cnt <= perf_flush_cnt + 32'(flush_discards);
    end
  end
`else
  assign perf_fetch_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu5_ifu.sv
// tb_cpu5_ifu: directed, table-driven bench for cpu5_ifu (XLEN=32, DEPTH=2).
// Each table row holds the inputs for one cycle and the outputs expected
// at the falling edge before those inputs are applied.
module tb_cpu5_ifu;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifu_valid;
  logic [31:0] ifu_instr;
  logic [31:0] ifu_pc;
  logic        ifu_ready;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;

  int assert_cnt;
  int fail_cnt;

  typedef struct {
    bit          rst_before;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[$];

  cpu5_ifu #(
    .XLEN     (32),
    .RESET_VEC(32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .ifu_valid     (ifu_valid),
    .ifu_instr     (ifu_instr),
    .ifu_pc        (ifu_pc),
    .ifu_ready     (ifu_ready),
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so a stuck run still ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    imem_gnt    = v.gnt;
    imem_rvalid = v.rvalid;
    imem_rdata  = v.rdata;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    ifu_ready   = v.rdy;
  endtask

  task automatic addVec(input bit rst, input logic gnt, input logic rv, input logic [31:0] rdata,
                        input logic redir, input logic [31:0] rpc, input logic rdy,
                        input logic ereq, input logic [31:0] eaddr, input logic evalid,
                        input logic [31:0] epc, input logic [31:0] einstr);
    vec_t v;
    v.rst_before = rst;
    v.gnt        = gnt;
    v.rvalid     = rv;
    v.rdata      = rdata;
    v.redir      = redir;
    v.rpc        = rpc;
    v.rdy        = rdy;
    v.exp_req    = ereq;
    v.exp_addr   = eaddr;
    v.exp_valid  = evalid;
    v.exp_pc     = epc;
    v.exp_instr  = einstr;
    vecs.push_back(v);
  endtask

  // Assert reset at a falling edge, check the reset image, release at the next falling edge
  task automatic doReset();
    reset       = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ifu_ready   = 1'b0;
    #1;
    checkOutput("rst_req",   {31'h0, imem_req},  32'h0);
    checkOutput("rst_addr",  imem_addr,          32'h0);
    checkOutput("rst_valid", {31'h0, ifu_valid}, 32'h0);
    checkOutput("rst_instr", ifu_instr,          32'h0);
    checkOutput("rst_pc",    ifu_pc,             32'h0);
    checkOutput("rst_pfetch", perf_fetch_cnt,    32'h0);
    checkOutput("rst_pflush", perf_flush_cnt,    32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_fetch;
    logic [31:0] exp_flush;
    int          n;

    assert_cnt  = 0;
    fail_cnt    = 0;
    reset       = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ifu_ready   = 1'b0;

    // A: streaming fetch with ready=1, gnt=1, data one cycle after grant
    addVec(1, 1,0,32'h0,        0,32'h0,1, 0,32'h0,0,32'h0,32'h0);
    addVec(0, 1,0,32'h0,        0,32'h0,1, 1,32'h0,0,32'h0,32'h0);
    addVec(0, 1,1,32'hA000_0000,0,32'h0,1, 0,32'h0,0,32'h0,32'h0);
    addVec(0, 1,0,32'h0,        0,32'h0,1, 1,32'h4,1,32'h0,32'hA000_0000);
    addVec(0, 1,1,32'hA000_0004,0,32'h0,1, 0,32'h4,0,32'h0,32'h0);
    addVec(0, 1,0,32'h0,        0,32'h0,1, 1,32'h8,1,32'h4,32'hA000_0004);
    addVec(0, 1,1,32'hA000_0008,0,32'h0,1, 0,32'h8,0,32'h0,32'h0);
    addVec(0, 0,0,32'h0,        0,32'h0,1, 1,32'hC,1,32'h8,32'hA000_0008);
    addVec(0, 0,0,32'h0,        0,32'h0,1, 1,32'hC,0,32'h0,32'h0);
    // B: ready=0 fills both entries, fetch stops, resumes at 0x8 after pops
    addVec(1, 1,0,32'h0,        0,32'h0,0, 0,32'h0,0,32'h0,32'h0);
    addVec(0, 1,0,32'h0,        0,32'h0,0, 1,32'h0,0,32'h0,32'h0);
    addVec(0, 1,1,32'hB000_0000,0,32'h0,0, 0,32'h0,0,32'h0,32'h0);
    addVec(0, 1,0,32'h0,        0,32'h0,0, 1,32'h4,1,32'h0,32'hB000_0000);
    addVec(0, 1,1,32'hB000_0004,0,32'h0,0, 0,32'h4,1,32'h0,32'hB000_0000);
    addVec(0, 1,0,32'h0,        0,32'h0,0, 0,32'h8,1,32'h0,32'hB000_0000);
    addVec(0, 1,0,32'h0,        0,32'h0,0, 0,32'h8,1,32'h0,32'hB000_0000);
    addVec(0, 1,0,32'h0,        0,32'h0,1, 0,32'h8,1,32'h0,32'hB000_0000);
    addVec(0, 1,0,32'h0,        0,32'h0,0, 0,32'h8,1,32'h4,32'hB000_0004);
    addVec(0, 1,0,32'h0,        0,32'h0,0, 1,32'h8,1,32'h4,32'hB000_0004);
    addVec(0, 1,1,32'hB000_0008,0,32'h0,0, 0,32'h8,1,32'h4,32'hB000_0004);
    addVec(0, 1,0,32'h0,        0,32'h0,1, 0,32'hC,1,32'h4,32'hB000_0004);
    addVec(0, 1,0,32'h0,        0,32'h0,1, 0,32'hC,1,32'h8,32'hB000_0008);
    addVec(0, 0,0,32'h0,        0,32'h0,0, 1,32'hC,0,32'h0,32'h0);
    // C: redirect to 0x100 in WAIT, stale response dropped
    addVec(1, 0,0,32'h0,        0,32'h0,  0, 0,32'h0,  0,32'h0,32'h0);
    addVec(0, 1,0,32'h0,        0,32'h0,  0, 1,32'h0,  0,32'h0,32'h0);
    addVec(0, 0,1,32'hC000_0000,0,32'h0,  0, 0,32'h0,  0,32'h0,32'h0);
    addVec(0, 1,0,32'h0,        0,32'h0,  0, 1,32'h4,  1,32'h0,32'hC000_0000);
    addVec(0, 0,0,32'h0,        1,32'h100,0, 0,32'h4,  1,32'h0,32'hC000_0000);
    addVec(0, 0,1,32'hC000_0004,0,32'h0,  0, 0,32'h100,0,32'h0,32'h0);
    addVec(0, 1,0,32'h0,        0,32'h0,  0, 1,32'h100,0,32'h0,32'h0);
    addVec(0, 0,0,32'h0,        0,32'h0,  0, 0,32'h100,0,32'h0,32'h0);
    addVec(0, 0,1,32'hC000_0100,0,32'h0,  0, 0,32'h100,0,32'h0,32'h0);
    addVec(0, 0,0,32'h0,        0,32'h0,  0, 1,32'h104,1,32'h100,32'hC000_0100);
    // D: redirect to 0x203 with simultaneous rvalid and pop
    addVec(1, 0,0,32'h0,        0,32'h0,  0, 0,32'h0,  0,32'h0,32'h0);
    addVec(0, 1,0,32'h0,        0,32'h0,  0, 1,32'h0,  0,32'h0,32'h0);
    addVec(0, 0,1,32'hD000_0000,0,32'h0,  0, 0,32'h0,  0,32'h0,32'h0);
    addVec(0, 1,0,32'h0,        0,32'h0,  0, 1,32'h4,  1,32'h0,32'hD000_0000);
    addVec(0, 0,1,32'hD000_0004,1,32'h203,1, 0,32'h4,  1,32'h0,32'hD000_0000);
    addVec(0, 0,0,32'h0,        0,32'h0,  1, 1,32'h200,0,32'h0,32'h0);
    addVec(0, 1,0,32'h0,        0,32'h0,  0, 1,32'h200,0,32'h0,32'h0);
    addVec(0, 0,1,32'hD000_0200,0,32'h0,  0, 0,32'h200,0,32'h0,32'h0);
    addVec(0, 0,0,32'h0,        0,32'h0,  0, 1,32'h204,1,32'h200,32'hD000_0200);
    // E: PC wrap at 0xFFFF_FFFC, redirect with grant -> DROP, rvalid in REQ ignored
    addVec(1, 0,0,32'h0,        1,32'hFFFF_FFFC,0, 0,32'h0,        0,32'h0,        32'h0);
    addVec(0, 1,0,32'h0,        0,32'h0,        0, 1,32'hFFFF_FFFC,0,32'h0,        32'h0);
    addVec(0, 0,1,32'hE000_0000,0,32'h0,        0, 0,32'hFFFF_FFFC,0,32'h0,        32'h0);
    addVec(0, 0,0,32'h0,        0,32'h0,        1, 1,32'h0,        1,32'hFFFF_FFFC,32'hE000_0000);
    addVec(0, 1,0,32'h0,        1,32'h40,       0, 1,32'h0,        0,32'h0,        32'h0);
    addVec(0, 0,0,32'h0,        0,32'h0,        0, 0,32'h40,       0,32'h0,        32'h0);
    addVec(0, 0,1,32'hE000_0004,0,32'h0,        0, 0,32'h40,       0,32'h0,        32'h0);
    addVec(0, 0,1,32'hE000_0008,0,32'h0,        0, 1,32'h40,       0,32'h0,        32'h0);
    addVec(0, 0,0,32'h0,        0,32'h0,        0, 1,32'h40,       0,32'h0,        32'h0);

    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].rst_before) begin
        doReset();
      end
      checkOutput($sformatf("v%0d_req", i),   {31'h0, imem_req},  {31'h0, vecs[i].exp_req});
      checkOutput($sformatf("v%0d_addr", i),  imem_addr,          vecs[i].exp_addr);
      checkOutput($sformatf("v%0d_valid", i), {31'h0, ifu_valid}, {31'h0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("v%0d_pc", i),    ifu_pc,    vecs[i].exp_pc);
        checkOutput($sformatf("v%0d_instr", i), ifu_instr, vecs[i].exp_instr);
      end
      applyStimulus(vecs[i]);
    end

    // Performance sequence: five fetches, one flushing redirect, one non-flushing redirect
    @(negedge clk);
    doReset();
    ifu_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!imem_req && n < 20) begin
        @(negedge clk);
        n++;
      end
      checkOutput($sformatf("perf_req%0d", k), {31'h0, imem_req}, 32'h1);
      checkOutput($sformatf("perf_addr%0d", k), imem_addr, 32'(4 * k));
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hF000_0000 + 32'(k);
      @(negedge clk);
      imem_rvalid = 1'b0;
      checkOutput($sformatf("perf_pc%0d", k), ifu_pc, 32'(4 * k));
      checkOutput($sformatf("perf_instr%0d", k), ifu_instr, 32'hF000_0000 + 32'(k));
    end
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    @(negedge clk);
    checkOutput("perf_flushed", {31'h0, ifu_valid}, 32'h0);
    redirect_pc = 32'h84;
    @(negedge clk);
    redirect = 1'b0;
    checkOutput("perf_newaddr", imem_addr, 32'h84);
`ifdef CPU5_IFU_PERF_EN
    exp_fetch = 32'd5;
    exp_flush = 32'd1;
`else
    exp_fetch = 32'd0;
    exp_flush = 32'd0;
`endif
    checkOutput("perf_fetch_cnt", perf_fetch_cnt, exp_fetch);
    checkOutput("perf_flush_cnt", perf_flush_cnt, exp_flush);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
